// File: rtl/uart_rx_frontend_if.sv
// Received-byte hand-off between the UART receiver (master) and its consumer (slave).
interface uart_rx_frontend_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ack;

  modport master (output data_out, output data_valid, input data_ack);
  modport slave  (input data_out, input data_valid, output data_ack);
endinterface

// File: rtl/uart_rx_frontend.sv
// 16x-oversampling UART receiver with a single-entry holding register and overrun/framing flags.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx_frontend #(
  parameter int unsigned OVS_DIV   = 27,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               rx,
  uart_rx_frontend_if.master bus,
  output logic               framing_error,
  output logic               overrun,
  output logic [2:0]         state
`ifdef UART_RX_PARITY_EN
  ,
  output logic               parity_error
`endif
);

  localparam int unsigned TICK_W = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int unsigned SAMP_W = 4;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_START  = 3'b001,
    S_DATA   = 3'b010,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'b011,
`endif
    S_STOP   = 3'b100
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rx_meta;
  logic                r_rx_sync;
  logic                r_rx_prev;
  logic [TICK_W-1:0]   r_tick_cnt;
  logic [SAMP_W-1:0]   r_samp_cnt;
  logic [BIT_W-1:0]    r_bit_cnt;
  logic [BYTE_W-1:0]   r_shift;
  logic [BYTE_W-1:0]   r_data;
  logic                r_valid;
  logic                r_ferr;
  logic                r_ovr;
  logic                w_fall;
  logic                w_tick;
  logic                w_half;
  logic                w_mid;
  logic                w_ack;
  logic                w_samp_clr;
  logic                w_shift_en;
  logic                w_done;
  logic                w_ferr;
`ifdef UART_RX_PARITY_EN
  logic                r_perr;
  logic                r_par_bad;
  logic                w_perr;
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_sync;
  assign w_tick = (r_state != S_IDLE) && (r_tick_cnt == TICK_W'(OVS_DIV - 1));
  assign w_half = w_tick && (r_samp_cnt == SAMP_W'(7));
  assign w_mid  = w_tick && (r_samp_cnt == SAMP_W'(15));
  assign w_ack  = bus.data_ack & r_valid;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_samp_clr  = 1'b0;
    w_shift_en  = 1'b0;
    w_done      = 1'b0;
    w_ferr      = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perr      = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_half) begin
          w_samp_clr  = 1'b1;
          w_state_nxt = r_rx_sync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_mid) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_mid) begin
          w_perr      = ^{r_shift, r_rx_sync};
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_mid) begin
          w_state_nxt = S_IDLE;
          w_ferr      = ~r_rx_sync;
`ifdef UART_RX_PARITY_EN
          w_done      = r_rx_sync & ~r_par_bad;
`else
          w_done      = r_rx_sync;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Counters run only inside a frame and are held at zero in IDLE
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_tick_cnt <= '0;
      r_samp_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_state == S_IDLE) begin
      r_tick_cnt <= '0;
      r_samp_cnt <= '0;
      r_bit_cnt  <= '0;
    end else begin
      if (w_tick) r_tick_cnt <= '0;
      else        r_tick_cnt <= r_tick_cnt + TICK_W'(1);
      if (w_samp_clr)  r_samp_cnt <= '0;
      else if (w_tick) r_samp_cnt <= r_samp_cnt + SAMP_W'(1);
      if (w_shift_en) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
    end
  end

  // Holding register: a same-cycle ack frees the slot for the incoming byte
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ferr <= w_ferr;
      if (w_shift_en) r_shift <= {r_rx_sync, r_shift[BYTE_W-1:1]};
      if (w_done && (!r_valid || w_ack)) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (w_ack) begin
        r_valid <= 1'b0;
      end
      if (w_ack)                  r_ovr <= 1'b0;
      else if (w_done && r_valid) r_ovr <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  // A bad parity bit poisons the frame until it ends
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
    end else begin
      r_perr <= w_perr;
      if (r_state == S_IDLE) r_par_bad <= 1'b0;
      else if (w_perr)       r_par_bad <= 1'b1;
    end
  end

  assign parity_error = r_perr;
`endif

  assign bus.data_out   = r_data;
  assign bus.data_valid = r_valid;
  assign framing_error  = r_ferr;
  assign overrun        = r_ovr;
  assign state          = r_state;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at OVS_DIV=4 (64 clocks per bit): frame table plus corner-case sequences.
module tb_uart_rx_frontend;

  localparam int unsigned BIT_CLKS = 64;
`ifdef UART_RX_PARITY_EN
  localparam int unsigned DONE_NEG = 674;
`else
  localparam int unsigned DONE_NEG = 610;
`endif

  logic       clock;
  logic       resetn;
  logic       rx;
  logic       framing_error;
  logic       overrun;
  logic [2:0] state;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  uart_rx_frontend_if u_bus ();

  uart_rx_frontend #(.OVS_DIV(4), .DATA_BITS(8)) u_dut (
    .clock         (clock),
    .resetn        (resetn),
    .rx            (rx),
    .bus           (u_bus),
    .framing_error (framing_error),
    .overrun       (overrun),
    .state         (state)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_error  (parity_error)
`endif
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;

  always @(posedge clock) begin
    if (framing_error) ferr_cnt <= ferr_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_error) perr_cnt <= perr_cnt + 1;
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 2000000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clock);
  endtask

  // Start, 8 data bits LSB first, correct even parity when enabled, stop, then short idle
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_b);
    rx = 1'b1;
    repeat (4) @(negedge clock);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par_b, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par_b);
    drive_bit(stop_b);
    rx = 1'b1;
    repeat (4) @(negedge clock);
  endtask
`endif

  task automatic do_ack();
    u_bus.data_ack = 1'b1;
    @(negedge clock);
    u_bus.data_ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] byte_v;
    logic       stop_v;
    logic       ack_v;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[7];
  int   f0;
  int   p0;
  int   lat;
  bit   seen_stop;
  bit   left_stop;
  bit   saw_start;
  bit   saw_valid;

  initial begin
    vecs[0] = '{8'hC3, 1'b1, 1'b1, 1'b1, 8'hC3, 0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 0, 1'b0};
    vecs[2] = '{8'h81, 1'b1, 1'b1, 1'b1, 8'h3C, 0, 1'b1};
    vecs[3] = '{8'h55, 1'b0, 1'b0, 1'b0, 8'h3C, 1, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 0, 1'b0};
    vecs[6] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 0, 1'b0};

    clock = 1'b0;
    resetn = 1'b0;
    rx = 1'b1;
    u_bus.data_ack = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_state", 32'(state), 32'h0);
    check("rst_data", 32'(u_bus.data_out), 32'h0);
    check("rst_valid", 32'(u_bus.data_valid), 32'h0);
    check("rst_ferr", 32'(framing_error), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);

    // 0xA5: valid within 3 clocks of the stop sample, held until ack
    seen_stop = 1'b0;
    left_stop = 1'b0;
    lat = 99;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int c = 0; c < 2000 && !seen_stop; c++) begin
          @(negedge clock);
          if (state == 3'b100) seen_stop = 1'b1;
        end
        for (int c = 0; c < 200 && seen_stop && !left_stop; c++) begin
          @(negedge clock);
          if (state != 3'b100) left_stop = 1'b1;
        end
        for (int c = 0; c <= 3 && left_stop && lat == 99; c++) begin
          if (u_bus.data_valid) lat = c;
          else @(negedge clock);
        end
      end
    join
    check("a5_left_stop", 32'(left_stop), 32'h1);
    check("a5_latency_le3", 32'(lat <= 3), 32'h1);
    check("a5_data", 32'(u_bus.data_out), 32'hA5);
    repeat (200) @(negedge clock);
    check("a5_hold_valid", 32'(u_bus.data_valid), 32'h1);
    check("a5_hold_data", 32'(u_bus.data_out), 32'hA5);
    do_ack();
    check("a5_ack_valid", 32'(u_bus.data_valid), 32'h0);

    for (int i = 0; i < 7; i++) begin
      f0 = ferr_cnt;
      send_frame(vecs[i].byte_v, vecs[i].stop_v);
      check($sformatf("v%0d_valid", i), 32'(u_bus.data_valid), 32'(vecs[i].exp_valid));
      check($sformatf("v%0d_data", i), 32'(u_bus.data_out), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_ferr_cycles", i), 32'(ferr_cnt - f0), 32'(vecs[i].exp_ferr));
      check($sformatf("v%0d_ovr", i), 32'(overrun), 32'(vecs[i].exp_ovr));
      if (vecs[i].ack_v) begin
        do_ack();
        check($sformatf("v%0d_ack_valid", i), 32'(u_bus.data_valid), 32'h0);
        check($sformatf("v%0d_ack_ovr", i), 32'(overrun), 32'h0);
        check($sformatf("v%0d_ack_data", i), 32'(u_bus.data_out), 32'(vecs[i].exp_data));
      end
    end

    // 20-clock glitch, with a stray ack while nothing is held
    f0 = ferr_cnt;
    saw_start = 1'b0;
    saw_valid = 1'b0;
    u_bus.data_ack = 1'b1;
    for (int c = 0; c < 120; c++) begin
      rx = (c < 20) ? 1'b0 : 1'b1;
      @(negedge clock);
      if (state == 3'b001) saw_start = 1'b1;
      if (u_bus.data_valid) saw_valid = 1'b1;
    end
    u_bus.data_ack = 1'b0;
    check("glitch_saw_start", 32'(saw_start), 32'h1);
    check("glitch_state", 32'(state), 32'h0);
    check("glitch_valid", 32'(saw_valid), 32'h0);
    check("glitch_ferr", 32'(ferr_cnt - f0), 32'h0);
    check("glitch_ovr", 32'(overrun), 32'h0);

    // Byte completing in the same cycle as the ack replaces the held byte
    send_frame(8'h6E, 1'b1);
    check("same_pre_data", 32'(u_bus.data_out), 32'h6E);
    fork
      send_frame(8'h9D, 1'b1);
      begin
        repeat (DONE_NEG) @(negedge clock);
        u_bus.data_ack = 1'b1;
        @(negedge clock);
        u_bus.data_ack = 1'b0;
      end
    join
    check("same_valid", 32'(u_bus.data_valid), 32'h1);
    check("same_data", 32'(u_bus.data_out), 32'h9D);
    check("same_ovr", 32'(overrun), 32'h0);
    do_ack();
    check("same_ack_valid", 32'(u_bus.data_valid), 32'h0);

`ifdef UART_RX_PARITY_EN
    p0 = perr_cnt;
    send_frame_par(8'h07, 1'b0, 1'b1);
    check("par_bad_pulse", 32'(perr_cnt - p0), 32'h1);
    check("par_bad_valid", 32'(u_bus.data_valid), 32'h0);
    p0 = perr_cnt;
    send_frame_par(8'h07, 1'b1, 1'b1);
    check("par_ok_pulse", 32'(perr_cnt - p0), 32'h0);
    check("par_ok_valid", 32'(u_bus.data_valid), 32'h1);
    check("par_ok_data", 32'(u_bus.data_out), 32'h07);
`endif

    // Reset in the middle of bit 4 of 0xFF
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clock);
    rx = 1'b1;
    repeat (4 * BIT_CLKS + 30) @(negedge clock);
    check("mid_state", 32'(state), 32'h2);
    resetn = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'h0);
    check("mid_rst_data", 32'(u_bus.data_out), 32'h0);
    check("mid_rst_valid", 32'(u_bus.data_valid), 32'h0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (BIT_CLKS * 6) @(negedge clock);
    check("post_rst_state", 32'(state), 32'h0);
    check("post_rst_valid", 32'(u_bus.data_valid), 32'h0);
    check("post_rst_ferr", 32'(ferr_cnt - f0), 32'h0);
    check("post_rst_ovr", 32'(overrun), 32'h0);
    send_frame(8'h12, 1'b1);
    check("r12_valid", 32'(u_bus.data_valid), 32'h1);
    check("r12_data", 32'(u_bus.data_out), 32'h12);
    check("r12_ovr", 32'(overrun), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

Interface
REQ-001 SHALL have parameter OVS_DIV, default 27, giving clocks per 16x oversample tick (50 MHz / (115200*16)).
REQ-002 SHALL have parameter DATA_BITS, default 8, as a fixed frame width; only 8 is supported.
REQ-003 SHALL have port clock  input  1  system clock; the only clock in the block.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx  input  1  serial line, asynchronous to clock, idle high.
REQ-006 SHALL have port data_out  output  8  received byte holding register.
REQ-007 SHALL have port data_valid  output  1  high while data_out holds an unconsumed byte.
REQ-008 SHALL have port data_ack  input  1  consumer (arbitrator) pops data_out.
REQ-009 SHALL have port framing_error  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 SHALL have port overrun  output  1  sticky flag: a byte was dropped because the holding register was full.
REQ-011 SHALL have port state  output  3  current FSM state, for debug.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all sampling SHALL use the synchronized value.
REQ-013 SHALL use a tick counter 0..OVS_DIV-1 that produces one tick per wrap, and SHALL count only while the FSM is not in IDLE.
REQ-014 SHALL use state encoding IDLE=000, START=001, DATA=010, PARITY=011, STOP=100.
REQ-015 IDLE: SHALL move to START on a synchronized rx high-to-low, clearing the tick and sample counters.
REQ-016 START: SHALL sample at the 8th tick (mid-bit); rx=0 SHALL go to DATA; rx=1 SHALL be a false start and SHALL go to IDLE with no flags.
REQ-017 DATA: SHALL sample every 16 ticks and shift in LSB first; after bit 7 it SHALL go to PARITY if enabled, else to STOP.
REQ-018 STOP: SHALL sample 16 ticks after the last bit, then return to IDLE the next clock; rx=0 SHALL pulse framing_error and discard the byte.
REQ-019 On a valid stop bit with data_valid=0, SHALL load data_out and set data_valid on the next clock edge.
REQ-020 data_valid SHALL stay high and data_out SHALL stay stable until data_ack is sampled high; ack while data_valid=0 SHALL be ignored.
REQ-021 If a byte completes while data_valid=1 and data_ack=0, SHALL drop the new byte, keep the old one, and set overrun.
REQ-022 If a byte completes in the same cycle as data_ack=1, SHALL load the new byte, keep data_valid=1, and not set overrun.
REQ-023 overrun SHALL clear on the cycle data_ack is accepted.
REQ-024 Line activity during STOP/return SHALL not be lost: a falling edge seen in IDLE the cycle after STOP SHALL start a new frame.

Reset
REQ-025 resetn=0 SHALL asynchronously force state=IDLE, data_out=0, data_valid=0, framing_error=0, overrun=0, all counters=0, and both synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the frame; no byte or flag SHALL be produced for it.

Configuration
REQ-027 SHALL use macro UART_RX_PARITY_EN to control parity support.
REQ-028 With UART_RX_PARITY_EN defined, SHALL add output parity_error (1 bit) and the PARITY state; even parity SHALL be checked at mid-bit, and a mismatch SHALL pulse parity_error and discard the byte.
REQ-029 With UART_RX_PARITY_EN undefined, SHALL have no PARITY state and no parity_error port; the frame SHALL be 8N1.

Verification (OVS_DIV=4, so bit period = 64 clocks)
REQ-030 Send 0xA5 in 8N1 -> data_out=0xA5 and data_valid=1 within 3 clocks after the stop mid-sample; it SHALL stay 1 until ack.
REQ-031 Send 0x3C then 0x81 without ack -> data_out=0x3C, overrun=1; after ack, data_valid=0 and overrun=0.
REQ-032 Drive a 20-clock low glitch on rx -> state returns to 000, no data_valid, no flags.
REQ-033 Send 0x55 with the stop bit low -> framing_error pulses exactly 1 clock and data_valid stays 0.
REQ-034 Assert resetn=0 during bit 4 of 0xFF, then release -> all outputs 0 and the next frame 0x12 is received correctly.
REQ-035 With UART_RX_PARITY_EN defined, send 0x07 with parity=0 (wrong) -> parity_error pulses and the byte is discarded; with parity=1 -> data_out=0x07.
